// File: rtl/order_entry_scheduler_if.sv
// Order-entry bus between the strategy requesters / matcher side and the scheduler.
interface order_entry_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_qty;
  logic [NUM_REQ*32-1:0] req_price;
  logic [NUM_REQ-1:0]    req_ack;
  logic                  halt;
  logic                  order_complete;
  logic [63:0]           sent_clordid;
  logic [31:0]           sent_qty;
  logic [31:0]           sent_price;
  logic                  order_sent_valid;
  logic [2:0]            sent_owner;
  logic [4:0]            open_count;
  logic [3:0]            tokens;
  logic [31:0]           issued_count;
  logic [31:0]           stall_count;

  // Requesters, kill switch and matcher completion side.
  modport master (
    output req_valid, req_qty, req_price, halt, order_complete,
    input  req_ack, sent_clordid, sent_qty, sent_price, order_sent_valid,
           sent_owner, open_count, tokens, issued_count, stall_count
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_qty, req_price, halt, order_complete,
    output req_ack, sent_clordid, sent_qty, sent_price, order_sent_valid,
           sent_owner, open_count, tokens, issued_count, stall_count
  );
endinterface

// File: rtl/order_entry_scheduler.sv
// Round-robin order-entry scheduler: arbitrates NUM_REQ strategies onto the
// single order path, assigns ClOrdIDs, caps open orders and rate-limits sends
// with a token bucket. Grants are blocked while halt is high.
module order_entry_scheduler #(
  parameter int          NUM_REQ        = 4,
  parameter int          MAX_OPEN       = 16,
  parameter int          TOKENS_MAX     = 8,
  parameter int          REFILL_CYCLES  = 100,
  parameter logic [31:0] CLORDID_PREFIX = 32'h4C4C5453
) (
  input logic                    clk,
  input logic                    rst,
  order_entry_scheduler_if.slave bus
);

  localparam int RW = $clog2(REFILL_CYCLES);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state;
  logic [2:0]    rr_ptr;
  logic [31:0]   seq;
  logic [RW-1:0] refill_cnt;
  logic          refill_tick;
  logic          eligible;
  logic          any_req;
  logic          win_found;
  logic [2:0]    win_idx;
  logic [3:0]    cand;
  logic [7:0]    req_pad;
  logic [31:0]   qty_arr   [8];
  logic [31:0]   price_arr [8];

  // Token count after a refill tick and/or a consume, capped at bucket size.
  function automatic logic [3:0] sat_tokens(input logic [3:0] cur, input logic tick,
                                            input logic consume);
    logic [4:0] t;
    t = {1'b0, cur} + 5'(tick) - 5'(consume);
    if (t > 5'(TOKENS_MAX)) t = 5'(TOKENS_MAX);
    return t[3:0];
  endfunction

  // Open-order count: a completion at zero is ignored, issue+complete cancel.
  function automatic logic [4:0] next_open(input logic [4:0] cur, input logic inc,
                                           input logic dec);
    logic dec_ok;
    dec_ok = dec && (cur != 5'd0);
    if (inc && !dec_ok)      return cur + 5'd1;
    else if (!inc && dec_ok) return cur - 5'd1;
    else                     return cur;
  endfunction

  // Sequence number skips 0 on wrap so every ClOrdID is non-zero.
  function automatic logic [31:0] next_seq(input logic [31:0] s);
    return (s == 32'hFFFF_FFFF) ? 32'd1 : s + 32'd1;
  endfunction

  function automatic logic [2:0] next_rr(input logic [2:0] w);
    logic [3:0] n;
    n = {1'b0, w} + 4'd1;
    if (n >= 4'(NUM_REQ)) n = 4'd0;
    return n[2:0];
  endfunction

  assign refill_tick = (refill_cnt == RW'(REFILL_CYCLES - 1));
  assign eligible    = !bus.halt && (bus.open_count < 5'(MAX_OPEN)) && (bus.tokens != 4'd0);
  assign any_req     = |bus.req_valid;
  assign req_pad     = 8'(bus.req_valid);

  // Unpack per-requester payload slices into fixed 8-entry tables.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      qty_arr[i]   = '0;
      price_arr[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      qty_arr[i]   = bus.req_qty[32*i +: 32];
      price_arr[i] = bus.req_price[32*i +: 32];
    end
  end

  // Round-robin pick: first valid requester at or after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!win_found && req_pad[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  // Scheduler FSM with registered strobes, counters and token bucket.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      seq                  <= 32'd1;
      refill_cnt           <= '0;
      bus.req_ack          <= '0;
      bus.order_sent_valid <= 1'b0;
      bus.open_count       <= '0;
      bus.tokens           <= 4'(TOKENS_MAX);
      bus.issued_count     <= '0;
      bus.stall_count      <= '0;
      bus.sent_clordid     <= '0;
      bus.sent_qty         <= '0;
      bus.sent_price       <= '0;
      bus.sent_owner       <= '0;
    end else begin
      refill_cnt     <= refill_tick ? '0 : refill_cnt + RW'(1);
      bus.tokens     <= sat_tokens(bus.tokens, refill_tick, state == ISSUE);
      bus.open_count <= next_open(bus.open_count, state == ISSUE, bus.order_complete);
      case (state)
        IDLE: begin
          if (any_req && eligible && win_found) begin
            state                <= ISSUE;
            bus.req_ack          <= NUM_REQ'(1) << win_idx;
            bus.order_sent_valid <= 1'b1;
            bus.sent_clordid     <= {CLORDID_PREFIX, seq};
            bus.sent_qty         <= qty_arr[win_idx];
            bus.sent_price       <= price_arr[win_idx];
            bus.sent_owner       <= win_idx;
          end else if (any_req) begin
            bus.stall_count <= bus.stall_count + 32'd1;
          end
        end
        ISSUE: begin
          state                <= IDLE;
          bus.req_ack          <= '0;
          bus.order_sent_valid <= 1'b0;
          seq                  <= next_seq(seq);
          bus.issued_count     <= bus.issued_count + 32'd1;
          rr_ptr               <= next_rr(bus.sent_owner);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
